// File: rtl/rr_stream_mux.sv
// Stream multiplexer: one of CHANNELS valid/ready inputs is forwarded to a single
// registered output, picked by an explicit select (MODE=0) or round-robin (MODE=1).
module rr_stream_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2,
    parameter int MODE     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic             load;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;

    // Channel index reached k steps after base, wrapping at CHANNELS (not 2**SELW).
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= CHANNELS) sum = sum - CHANNELS;
        return SELW'(sum);
    endfunction

    // The slot is free when empty or being drained this cycle; out_ready never
    // reaches the data path, only this enable.
    assign load = !out_valid_q || out_ready;

    // NOTE: every signal assigned in always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (MODE == 0) begin
            if ((int'(sel) < CHANNELS) && in_valid[sel]) begin
                gnt_valid = 1'b1;
                gnt_idx   = sel;
            end
        end else begin
            // Walk ptr+1, ptr+2, ... so the last winner has lowest priority.
            for (int k = 1; k <= CHANNELS; k++) begin
                if (!gnt_valid && in_valid[wrap_add(ptr_q, k)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = wrap_add(ptr_q, k);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load && gnt_valid) begin
            in_ready = CHANNELS'(1) << gnt_idx;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (gnt_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
                out_chan_d  = gnt_idx;
                if (MODE == 1) ptr_d = gnt_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SELW'(CHANNELS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: one select-driven and one round-robin instance share the
// same stimulus; a behavioural model is compared every cycle, plus literal checks.
module tb_rr_stream_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0]  in_ready0, in_ready1;
    logic [3:0]  data0, data1;
    logic [1:0]  chan0, chan1;
    logic        valid0, valid1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(4), .CHANNELS(4), .SELW(2), .MODE(0)) u_sel (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .sel(sel), .out_data(data0), .out_chan(chan0),
        .out_valid(valid0), .out_ready(out_ready)
    );

    rr_stream_mux #(.WIDTH(4), .CHANNELS(4), .SELW(2), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .sel(sel), .out_data(data1), .out_chan(chan1),
        .out_valid(valid1), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = select mode, 1 = round-robin)
    logic       m_valid [2];
    logic [3:0] m_data  [2];
    logic [1:0] m_chan  [2];
    int         m_ptr   [2];
    bit         m_init = 1'b0;

    // Winning channel under the arbitration rules, or -1 when nobody wins.
    function automatic int winner(input int m, input logic [1:0] s, input logic [3:0] v, input int p);
        if (m == 0) return v[s] ? int'(s) : -1;
        for (int k = 1; k <= 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int m);
        int w;
        w = winner(m, sel, in_valid, m_ptr[m]);
        if (!rst_n || (m_valid[m] && !out_ready) || w < 0) return 4'b0000;
        return 4'b0001 << w;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_valid[m] = 1'b0;
                m_data[m]  = 4'h0;
                m_chan[m]  = 2'd0;
                m_ptr[m]   = 3;
            end else if (!m_valid[m] || out_ready) begin
                int w;
                w = winner(m, sel, in_valid, m_ptr[m]);
                if (w >= 0) begin
                    m_valid[m] = 1'b1;
                    m_data[m]  = in_data[w*4 +: 4];
                    m_chan[m]  = 2'(w);
                    if (m == 1) m_ptr[m] = w;
                end else begin
                    m_valid[m] = 1'b0;
                end
            end
        end
        if (!rst_n) m_init = 1'b1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("sel_valid", 32'(valid0),    32'(m_valid[0]));
            check("sel_data",  32'(data0),     32'(m_data[0]));
            check("sel_chan",  32'(chan0),     32'(m_chan[0]));
            check("sel_ready", 32'(in_ready0), 32'(exp_ready(0)));
            check("rr_valid",  32'(valid1),    32'(m_valid[1]));
            check("rr_data",   32'(data1),     32'(m_data[1]));
            check("rr_chan",   32'(chan1),     32'(m_chan[1]));
            check("rr_ready",  32'(in_ready1), 32'(exp_ready(1)));
        end
    end

    // ---------------- directed stimulus with literal expectations
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] sel_seq  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] dat_seq  [6] = '{4'h1, 4'hA, 4'h8, 4'hD, 4'h1, 4'hA};
    logic [1:0] rr_chans [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        rst_n     = 1'b0;
        in_data   = 16'hD8A1;
        in_valid  = 4'hF;
        sel       = 2'd0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_valid0", 32'(valid0), 0);
        check("rst_data0",  32'(data0), 0);
        check("rst_chan0",  32'(chan0), 0);
        check("rst_ready0", 32'(in_ready0), 0);
        check("rst_ready1", 32'(in_ready1), 0);

        // Select sweep and round-robin wrap from reset
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sel = sel_seq[i];
            step();
            check("sweep_data0",  32'(data0), 32'(dat_seq[i]));
            check("sweep_chan0",  32'(chan0), 32'(sel_seq[i]));
            check("sweep_valid0", 32'(valid0), 1);
            check("wrap_chan1",   32'(chan1), 32'(rr_chans[i]));
            check("wrap_data1",   32'(data1), 32'(dat_seq[i]));
        end

        // Sparse valids after a grant to ch1: ch3 then ch1; select on idle ch2
        sel      = 2'd2;
        in_valid = 4'b1010;
        #1;
        check("sparse_ready0", 32'(in_ready0), 0);
        check("sparse_ready1", 32'(in_ready1), 32'b1000);
        step();
        check("sparse_valid0", 32'(valid0), 0);
        check("sparse_chan1a", 32'(chan1), 3);
        check("sparse_data1a", 32'(data1), 32'hD);
        step();
        check("sparse_chan1b", 32'(chan1), 1);
        check("sparse_data1b", 32'(data1), 32'hA);

        sel      = 2'd0;
        in_valid = 4'hF;
        step();
        check("refill_valid0", 32'(valid0), 1);
        sel      = 2'd2;
        in_valid = 4'b1011;
        #1;
        check("nogrant_ready0", 32'(in_ready0), 0);
        step();
        check("nogrant_valid0", 32'(valid0), 0);
        check("nogrant_data0",  32'(data0), 1);

        // Stall with data A held; sel/in_valid wiggle underneath
        sel      = 2'd1;
        in_valid = 4'hF;
        step();
        check("prestall_data0", 32'(data0), 32'hA);
        check("prestall_chan1", 32'(chan1), 0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel      = 2'(i + 2);
            in_valid = (i == 1) ? 4'b0110 : 4'b1001;
            #1;
            check("stall_ready0", 32'(in_ready0), 0);
            check("stall_ready1", 32'(in_ready1), 0);
            step();
            check("stall_data0",  32'(data0), 32'hA);
            check("stall_valid0", 32'(valid0), 1);
            check("stall_data1",  32'(data1), 1);
        end
        out_ready = 1'b1;
        in_valid  = 4'hF;
        sel       = 2'd3;
        #1;
        check("release_ready0", 32'(in_ready0), 32'b1000);
        check("release_ready1", 32'(in_ready1), 32'b0010);
        step();
        check("release_data0", 32'(data0), 32'hD);
        check("release_chan1", 32'(chan1), 1);

        // Reset while holding a word
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        check("midrst_valid0", 32'(valid0), 0);
        check("midrst_data0",  32'(data0), 0);
        check("midrst_valid1", 32'(valid1), 0);
        check("midrst_data1",  32'(data1), 0);
        out_ready = 1'b1;
        #1;
        check("midrst_ready1", 32'(in_ready1), 0);
        step();
        rst_n = 1'b1;
        step();
        check("postrst_chan1", 32'(chan1), 0);
        check("postrst_data1", 32'(data1), 1);

        // Idle: valid drops, data and channel hold
        in_valid = 4'h0;
        step();
        check("idle_valid1", 32'(valid1), 0);
        check("idle_data1",  32'(data1), 1);
        check("idle_chan1",  32'(chan1), 0);

        // Mixed traffic checked by the model only
        for (int i = 0; i < 60; i++) begin
            in_data   = 16'($urandom);
            in_valid  = 4'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4, meaning the data bits per channel.
REQ-002 The block SHALL provide parameter CHANNELS, default 4, meaning the number of input channels; the legal range is 2..16.
REQ-003 The block SHALL provide parameter SELW, default 2, meaning the select/channel-index width; the integrator sets it so that 2**SELW >= CHANNELS.
REQ-004 The block SHALL provide parameter MODE, default 0, meaning the arbitration mode: 0 = select-driven, 1 = round-robin.
REQ-005 The block SHALL provide these ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel accept strobe (combinational).
- sel  input  SELW  channel select, used only when MODE=0.
- out_data  output  WIDTH  registered output data.
- out_chan  output  SELW  index of the channel that sourced out_data.
- out_valid  output  1  output holds a word.
- out_ready  input  1  downstream accepts the word.

Function
REQ-006 The block SHALL define load = !out_valid || out_ready.
REQ-007 MODE=0: the grant SHALL be channel sel when sel < CHANNELS and in_valid[sel]=1; otherwise there is no grant.
REQ-008 MODE=1: the grant SHALL be the first channel with in_valid=1, searching ptr+1, ptr+2, ... modulo CHANNELS, where ptr is the last accepted channel.
REQ-009 in_ready[i] SHALL be 1 only when load=1, a grant exists, and the grant equals i; at most one bit is set per cycle.
REQ-010 A transfer SHALL occur on any edge where in_valid[i] && in_ready[i]; out_data, out_chan and out_valid (=1) SHALL take the channel's values on that edge, giving 1-cycle latency.
REQ-011 When load=1 and there is no grant, out_valid SHALL become 0 on the next edge; out_data and out_chan SHALL hold their previous values.
REQ-012 When out_valid=1 and out_ready=0 (stall), out_data, out_chan and out_valid SHALL hold stable, and all in_ready bits SHALL be 0.
REQ-013 Throughput SHALL be one word per cycle while out_ready=1 and a grant exists.
REQ-014 ptr SHALL update to the granted index only on a transfer; it SHALL NOT change on idle or stall cycles, or at any time in MODE=0.
REQ-015 ptr SHALL wrap: with ptr=CHANNELS-1, the search SHALL start at channel 0.
REQ-016 A change of sel or in_valid during a stall SHALL NOT alter the held output.
REQ-017 The grant SHALL be a function of current inputs and ptr only; the block SHALL have no combinational path from out_ready to out_data.

Reset
REQ-018 When rst_n=0 at a rising edge, the block SHALL set out_valid=0, out_data=0, out_chan=0 and ptr=CHANNELS-1, so the first round-robin search starts at channel 0.
REQ-019 While rst_n=0, all in_ready bits SHALL be 0.
REQ-020 A reset asserted mid-stream SHALL discard any held word; no transfer SHALL be counted on that edge.

Verification
REQ-021 The bench SHALL cover MODE=0 with in_data=16'hD8A1 (ch0=1, ch1=A, ch2=8, ch3=D), all in_valid=1, out_ready=1, and sel stepping 0,1,2,3 -> out_data 1,A,8,D with out_chan 0,1,2,3, each one cycle after its sel value.
REQ-022 The bench SHALL cover MODE=0 with sel=2, in_valid=4'b1011 -> in_ready=0 and out_valid drops to 0 after one cycle.
REQ-023 The bench SHALL cover MODE=1 with all in_valid=1 and out_ready=1 from reset -> out_chan sequence 0,1,2,3,0,1 (pointer wrap).
REQ-024 The bench SHALL cover MODE=1 with in_valid=4'b1010 after a grant to ch1 -> next grant ch3, then ch1.
REQ-025 The bench SHALL cover a stall: out_ready=0 for 3 cycles while out_valid=1 and out_data=A -> out_data stays A, in_ready=0, and ptr is unchanged; on release with out_ready=1 the next word loads on the same edge.
REQ-026 The bench SHALL cover rst_n=0 asserted while out_valid=1 -> on the next edge out_valid=0 and out_data=0; after release, the first round-robin grant goes to channel 0.
